// File: rtl/spi_slave.sv
// MMIO-mapped SPI target: 2-FF synchronized pins, single-byte TX buffer / RX register, per-byte IRQ pulse.
// Pin-to-action latency 3 clk; bus access acked one cycle after request, never stalls.
module spi_slave (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mmio_valid,
   input  logic        mmio_write,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_wdata,
   input  logic [3:0]  mmio_wstrb,
   output logic [31:0] mmio_rdata,
   output logic        mmio_ready,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        spi_cs_n,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        spi_irq
);
   localparam logic [31:0] ADDR_CTRL   = 32'h8000_0060;
   localparam logic [31:0] ADDR_DATA   = 32'h8000_0064;
   localparam logic [31:0] ADDR_STATUS = 32'h8000_0068;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
   state_t state, state_nxt;

   logic       sck_s1, sck_s2, sck_s3, mosi_s1, mosi_s2, cs_s1, cs_s2, cs_s3;
   logic       ctrl_cpol, ctrl_cpha, ctrl_en, cpol_l, cpha_l;
   logic [7:0] tx_buf, shift_tx, rx_data, load_byte, rx_byte;
   logic [6:0] rx_shift;
   logic [2:0] bit_cnt;
   logic       tx_full, rx_valid, overrun, underrun, under_pend;
   logic       req, wr_en, ctrl_wr, data_wr, stat_wr, data_rd;
   logic       cs_fall, cs_rise, sck_rise, sck_fall, lead, trail;
   logic       frame_start, frame_end, sample_evt, shift_evt, byte_done, tx_take;
   logic       unused_bits;

   assign unused_bits = ^{mmio_wdata[31:8], mmio_wstrb[3:1]};

   assign req     = mmio_valid && !mmio_ready;
   assign wr_en   = req && mmio_write && mmio_wstrb[0];
   assign ctrl_wr = wr_en && (mmio_addr == ADDR_CTRL);
   assign data_wr = wr_en && (mmio_addr == ADDR_DATA);
   assign stat_wr = wr_en && (mmio_addr == ADDR_STATUS);
   assign data_rd = req && !mmio_write && (mmio_addr == ADDR_DATA);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         {sck_s1, sck_s2, sck_s3} <= 3'b000;
         {mosi_s1, mosi_s2}       <= 2'b00;
         {cs_s1, cs_s2, cs_s3}    <= 3'b111;
      end else begin
         {sck_s1, sck_s2, sck_s3} <= {spi_sck, sck_s1, sck_s2};
         {mosi_s1, mosi_s2}       <= {spi_mosi, mosi_s1};
         {cs_s1, cs_s2, cs_s3}    <= {spi_cs_n, cs_s1, cs_s2};
      end
   end

   assign cs_fall   = cs_s3 && !cs_s2;
   assign cs_rise   = !cs_s3 && cs_s2;
   assign sck_rise  = !sck_s3 && sck_s2;
   assign sck_fall  = sck_s3 && !sck_s2;
   assign byte_done = sample_evt && (bit_cnt == 3'd7);
   assign tx_take   = frame_start || byte_done;
   assign load_byte = tx_full ? tx_buf : 8'hFF;
   assign rx_byte   = {rx_shift, mosi_s2};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      sample_evt  = 1'b0;
      shift_evt   = 1'b0;
      lead        = cpol_l ? sck_fall : sck_rise;
      trail       = cpol_l ? sck_rise : sck_fall;
      case (state)
         IDLE: begin
            if (cs_fall && ctrl_en) begin
               state_nxt   = ACTIVE;
               frame_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise || !ctrl_en) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end else begin
               sample_evt = cpha_l ? trail : lead;
               // cpha=0 drives the reloaded MSB at byte completion, so the following trailing edge must not shift
               shift_evt  = cpha_l ? lead : (trail && (bit_cnt != 3'd0));
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
         bit_cnt     <= 3'd0;
         rx_shift    <= 7'd0;
         shift_tx    <= 8'hFF;
         spi_miso    <= 1'b1;
         spi_miso_oe <= 1'b0;
      end else if (frame_start) begin
         cpol_l      <= ctrl_cpol;
         cpha_l      <= ctrl_cpha;
         bit_cnt     <= 3'd0;
         spi_miso_oe <= 1'b1;
         if (ctrl_cpha) begin
            shift_tx <= load_byte;
         end else begin
            spi_miso <= load_byte[7];
            shift_tx <= {load_byte[6:0], 1'b1};
         end
      end else if (frame_end) begin
         bit_cnt     <= 3'd0;
         spi_miso    <= 1'b1;
         spi_miso_oe <= 1'b0;
      end else begin
         if (sample_evt) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte[6:0];
         end
         if (byte_done) begin
            if (cpha_l) begin
               shift_tx <= load_byte;
            end else begin
               spi_miso <= load_byte[7];
               shift_tx <= {load_byte[6:0], 1'b1};
            end
         end else if (shift_evt) begin
            spi_miso <= shift_tx[7];
            shift_tx <= {shift_tx[6:0], 1'b1};
         end
      end
   end

   // A reload without data only counts as underrun once the master actually clocks into the next byte.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_buf     <= 8'd0;
         tx_full    <= 1'b0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         overrun    <= 1'b0;
         underrun   <= 1'b0;
         under_pend <= 1'b0;
         spi_irq    <= 1'b0;
      end else begin
         spi_irq <= byte_done;
         if (data_wr) begin
            tx_buf  <= mmio_wdata[7:0];
            tx_full <= 1'b1;
         end else if (tx_take) begin
            tx_full <= 1'b0;
         end
         if (byte_done) begin
            rx_data  <= rx_byte;
            rx_valid <= 1'b1;
         end else if (data_rd) begin
            rx_valid <= 1'b0;
         end
         if (byte_done && rx_valid && !data_rd) overrun <= 1'b1;
         else if (stat_wr && mmio_wdata[2])     overrun <= 1'b0;
         if (frame_start || frame_end)           under_pend <= 1'b0;
         else if (byte_done)                     under_pend <= !tx_full;
         else if (sample_evt || shift_evt)       under_pend <= 1'b0;
         if ((frame_start && !tx_full) || (under_pend && (sample_evt || shift_evt)))
            underrun <= 1'b1;
         else if (stat_wr && mmio_wdata[3])
            underrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ctrl_cpol  <= 1'b0;
         ctrl_cpha  <= 1'b0;
         ctrl_en    <= 1'b0;
         mmio_ready <= 1'b0;
         mmio_rdata <= 32'd0;
      end else begin
         mmio_ready <= req;
         mmio_rdata <= 32'd0;
         if (ctrl_wr) {ctrl_en, ctrl_cpha, ctrl_cpol} <= mmio_wdata[2:0];
         if (req && !mmio_write) begin
            case (mmio_addr)
               ADDR_CTRL:   mmio_rdata <= {29'd0, ctrl_en, ctrl_cpha, ctrl_cpol};
               ADDR_DATA:   mmio_rdata <= {24'd0, rx_data};
               ADDR_STATUS: mmio_rdata <= {27'd0, state == ACTIVE, underrun, overrun, tx_full, rx_valid};
               default:     mmio_rdata <= 32'd0;
            endcase
         end
      end
   end
endmodule

// File: doc/spi_slave.md
# spi_slave

Memory-mapped SPI slave (target) peripheral for the PicoRV32 MMIO bus, occupying 0x80000060–0x8000006C, alongside the existing SPI master. An external SPI master clocks bytes in and out through a single-byte TX holding buffer and RX data register. All SPI pins are asynchronous and are oversampled into the `clk` domain, and a single-cycle IRQ pulse marks each completed byte.

## Interface
- No parameters; the register base is fixed at 0x80000060.
- clk  in  1  system clock, 50 MHz
- resetn  in  1  reset; asynchronous, active-low
- mmio_valid  in  1  bus request
- mmio_write  in  1  1 = write, 0 = read
- mmio_addr  in  32  byte address
- mmio_wdata  in  32  write data
- mmio_wstrb  in  4  byte enables; only bit 0 is used
- mmio_rdata  out  32  read data (registered)
- mmio_ready  out  1  one-cycle acknowledge
- spi_sck  in  1  external SCK (asynchronous)
- spi_mosi  in  1  external MOSI (asynchronous)
- spi_cs_n  in  1  external chip select, active low (asynchronous)
- spi_miso  out  1  MISO data
- spi_miso_oe  out  1  MISO output enable (tristate is done at top level)
- spi_irq  out  1  single-cycle pulse per received byte

## Operation
- Registers. Accesses to any other address are acked; reads return 0.
  - CTRL 0x60: bit 0 cpol, bit 1 cpha, bit 2 enable. Reset value 0.
  - DATA 0x64, write: load tx_buf and set tx_full. A write while tx_full is already set overwrites tx_buf.
  - DATA 0x64, read: return rx_data and clear rx_valid.
  - STATUS 0x68, read: {27'h0, cs_active, underrun, overrun, tx_full, rx_valid}.
  - STATUS 0x68, write: a 1 in bit 2 clears overrun; a 1 in bit 3 clears underrun.
- Bus handshake: identical to the SPI master. Respond when `mmio_valid && !mmio_ready`. `mmio_ready` is registered high for exactly one cycle. The block never stalls.
- Pin synchronizers:
  - `spi_sck`, `spi_mosi` and `spi_cs_n` each pass through a 2-FF synchronizer.
  - A third flop on `spi_sck` and on `spi_cs_n` provides edge detection.
- Frame start (synced CS falling edge while enable = 1):
  - Latch cpol/cpha into frame-local copies; mid-frame CTRL writes do not affect the current frame.
  - Clear bit_cnt and assert `spi_miso_oe`.
  - Load shift_tx from tx_buf if tx_full (then clear tx_full). Otherwise load 0xFF and set underrun.
  - If cpha = 0, drive `spi_miso` = shift_tx[7] immediately.
- SCK edges (using the latched cpol):
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
  - cpha = 0: sample MOSI on the leading edge; shift MISO out on the trailing edge.
  - cpha = 1: shift MISO out on the leading edge; sample on the trailing edge.
  - Data is MSB-first.
- Byte complete (8th sample):
  - rx_data <= shifted byte.
  - If rx_valid is already 1, set overrun; new data still overwrites rx_data.
  - Set rx_valid; pulse irq.
  - bit_cnt wraps to 0, and shift_tx reloads from tx_buf (or 0xFF with underrun) for back-to-back bytes within one CS assertion.
  - The first MISO bit of the reloaded byte goes out: cpha = 0 immediately at reload; cpha = 1 on the next leading edge.
- Frame end (synced CS rising edge):
  - Deassert `spi_miso_oe`.
  - Discard any partial byte (no rx update, no irq) and clear bit_cnt.
- enable = 0: the SPI engine is idle, edges are ignored and `spi_miso_oe` = 0. Registers remain accessible.
- State machine:
  - IDLE → ACTIVE on CS fall with enable = 1.
  - ACTIVE → IDLE on CS rise.
  - ACTIVE → IDLE if enable is cleared (partial byte discarded).

## Timing
- Reset values: mmio_rdata 0, mmio_ready 0, spi_miso 1, spi_miso_oe 0, spi_irq 0. All flags, tx_buf and rx_data are 0.
- Pin-to-action latency: 3 clk cycles from an external SCK or CS edge to the internal action or MISO update.
- Maximum supported SCK is clk/8 (6.25 MHz). Each SCK half-period must be at least 4 clk cycles.
- Byte completion: rx_valid and spi_irq assert together, 3 cycles after the 8th sampling SCK edge.
- Simultaneous DATA read and byte completion: the read returns the old rx_data, and rx_valid ends up set with the new byte. Overrun is not flagged.
- Simultaneous DATA write and tx reload: the reload consumes the old tx_buf. The new write lands in tx_buf with tx_full = 1.
- Reset asserted mid-frame: all state returns to reset values; the block waits for a fresh CS fall.

## Test plan
- Mode 0: CTRL = 0x4, write DATA 0xA5, master sends 0x3C at clk/8 → master receives 0xA5; rx_data = 0x3C; one irq pulse; STATUS = 0x11 while CS is low.
- Modes 1, 2 and 3, each with tx 0x81 and rx 0x7E → correct bytes in both directions for each mode.
- Two bytes in one frame without reading DATA in between → rx_data = second byte, overrun = 1; writing 0x4 to STATUS clears it.
- No DATA write before the frame → MISO sends 0xFF and underrun = 1.
- CS raised after 5 bits → no irq, rx_valid unchanged; the next full frame transfers correctly.
- Reset pulsed mid-byte → all outputs at reset values; a subsequent transfer succeeds.
